// File: rtl/fir_capture_pkg.sv
// Shared types and defaults for the FIR output capture buffer.
// Holds the controller state encoding and the capture-length clamp helper.
package fir_capture_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 10;
  localparam int SKIP_W_DEFAULT = 8;
  localparam int DEPTH_DEFAULT  = 1000;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    CAPTURE,
    READOUT,
    DONE
  } state_t;

  // A request of zero, or one larger than the RAM, means "fill the whole RAM".
  function automatic int effective_len(input int requested, input int depth);
    return (requested == 0 || requested > depth) ? depth : requested;
  endfunction

endpackage

// File: rtl/capture_sample_ram.sv
// Simple dual-port sample store: one write port and one synchronous read port.
// Read data appears one clock after re is asserted and holds until the next read.
module capture_sample_ram
  import fir_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // NOTE: the array has no reset so it maps onto block RAM; readers never see
  // an address before it has been written in the current capture.
  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: non-blocking assignments keep same-edge reads and writes race-free.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fir_capture_buffer.sv
// Captures a window of FIR output samples after a programmable settling skip,
// then streams them out on a valid/ready port through a two-deep skid stage.
module fir_capture_buffer
  import fir_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int SKIP_W = SKIP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SKIP_W-1:0] skip_count,
  input  logic [ADDR_W-1:0] capture_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_index,
  output logic              rd_last
);

  state_t state, state_nx;

  logic [SKIP_W-1:0] skip_cnt;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              issued_all;

  logic              ram_v;
  logic [ADDR_W-1:0] ram_idx;
  logic [DATA_W-1:0] ram_q;

  logic              sk_v;
  logic [DATA_W-1:0] sk_data;
  logic [ADDR_W-1:0] sk_idx;

  logic       start_ok;
  logic       wr_en;
  logic       pop;
  logic [1:0] occ;
  logic       issue;
  logic       out_load;
  logic       ram_to_out;
  logic       ram_to_sk;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign wr_en    = (state == CAPTURE) && in_valid;
  assign pop      = rd_valid && rd_ready;

  // Beats held in output + skid + RAM pipe never exceed two, so a read is
  // issued only when a slot will be free by the time its data lands.
  assign occ   = 2'(rd_valid) + 2'(sk_v) + 2'(ram_v);
  assign issue = (state == READOUT) && !issued_all && (occ != 2'd2 || pop);

  assign out_load   = !rd_valid || pop;
  assign ram_to_out = out_load && !sk_v && ram_v;
  assign ram_to_sk  = ram_v && !ram_to_out;

  capture_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_data),
    .re    (issue),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = (skip_count != '0) ? SKIP : CAPTURE;
      SKIP:       if (in_valid && skip_cnt == SKIP_W'(1)) state_nx = CAPTURE;
      CAPTURE:    if (in_valid && wr_ptr == last_idx) state_nx = READOUT;
      READOUT:    if (pop && rd_last) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      SKIP, CAPTURE, READOUT: busy = 1'b1;
      DONE:                   done = 1'b1;
      default:                ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt   <= '0;
      last_idx   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      issued_all <= 1'b0;
    end else if (start_ok) begin
      skip_cnt   <= skip_count;
      last_idx   <= ADDR_W'(effective_len(int'(capture_len), DEPTH) - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      issued_all <= 1'b0;
    end else begin
      if (state == SKIP && in_valid) skip_cnt <= skip_cnt - SKIP_W'(1);
      // Pointers stop at the last index rather than wrapping past it.
      if (wr_en && wr_ptr != last_idx) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (issue) begin
        if (rd_ptr == last_idx) issued_all <= 1'b1;
        else                    rd_ptr     <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_v    <= 1'b0;
      ram_idx  <= '0;
      sk_v     <= 1'b0;
      sk_data  <= '0;
      sk_idx   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_index <= '0;
      rd_last  <= 1'b0;
    end else if (state != READOUT) begin
      ram_v    <= 1'b0;
      sk_v     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      ram_v <= issue;
      if (issue) ram_idx <= rd_ptr;

      // Output register refills from the skid first to preserve index order.
      if (out_load) begin
        if (sk_v) begin
          rd_valid <= 1'b1;
          rd_data  <= sk_data;
          rd_index <= sk_idx;
          rd_last  <= (sk_idx == last_idx);
        end else if (ram_v) begin
          rd_valid <= 1'b1;
          rd_data  <= ram_q;
          rd_index <= ram_idx;
          rd_last  <= (ram_idx == last_idx);
        end else begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end
      end

      if (ram_to_sk) begin
        sk_v    <= 1'b1;
        sk_data <= ram_q;
        sk_idx  <= ram_idx;
      end else if (out_load) begin
        sk_v <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fir_capture_buffer.md
Name: fir_capture_buffer

Overview:
Sink at the output end of the FIR sample stream; the counterpart of the stimulus player that drives `FIR_filter`. On `start` it discards a programmable number of leading samples (filter pipeline/settling latency), then stores a programmable number of output samples in on-chip RAM. It then streams them out on a valid/ready read port for dump to file or host. It replaces negedge sampling of `OUT` with a clocked, handshaked capture.

Parameters:
DATA_W, 16, sample width (matches filter `OUT`)
DEPTH, 1000, capture RAM depth in samples
ADDR_W, 10, index width; must satisfy 2^ADDR_W >= DEPTH
SKIP_W, 8, width of skip counter

Ports:
clk  in  1  single clock, all logic posedge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle arm pulse
skip_count  in  SKIP_W  valid input samples to discard after start
capture_len  in  ADDR_W  samples to store; 0 or >DEPTH means DEPTH
in_valid  in  1  qualifies in_data
in_data  in  DATA_W  filter output sample (`OUT`)
busy  out  1  high in SKIP, CAPTURE, READOUT
done  out  1  high in DONE
rd_valid  out  1  read beat valid
rd_ready  in  1  consumer accepts beat
rd_data  out  DATA_W  stored sample
rd_index  out  ADDR_W  sample index of current beat, 0-based
rd_last  out  1  high on final beat

Behaviour:
- Reset: clk/rst only, synchronous, active-high. Outputs after reset:
  - state = IDLE
  - busy = done = rd_valid = rd_last = 0
  - rd_data = rd_index = 0
  - all counters = 0
  - RAM contents not cleared
- rst wins over every other input in the same cycle. rst mid-operation aborts to IDLE; no partial beats are emitted afterwards.
- States: IDLE, SKIP, CAPTURE, READOUT, DONE.
- start is accepted only in IDLE or DONE; it is ignored while busy.
  - On acceptance, skip_count and the clamped capture_len are latched and done clears.
  - Next state is SKIP if skip_count != 0, otherwise CAPTURE.
- Sampling begins the cycle after start is accepted. in_data on the start cycle is never counted.
- SKIP: each cycle with in_valid=1 decrements the skip counter. When the final skipped sample arrives (counter == 1 and in_valid), move to CAPTURE. That sample is not stored.
- CAPTURE:
  - Each cycle with in_valid=1 writes in_data to RAM[wr_ptr] and increments wr_ptr.
  - Cycles with in_valid=0 are ignored; no write, no count.
  - Once the latched length has been written (the last write cycle), go to READOUT.
- READOUT:
  - RAM read is synchronous with 1-cycle latency.
  - rd_valid asserts no later than 2 cycles after READOUT entry.
  - Beats are presented in index order 0..len-1 with rd_index = stored position.
  - A beat transfers when rd_valid && rd_ready.
  - rd_data, rd_index, rd_last hold stable while rd_valid && !rd_ready.
  - With rd_ready held high, throughput is 1 beat/cycle, no bubbles after the first beat. This needs a prefetch/skid register.
  - rd_last = 1 only on index len-1. Its transfer moves to DONE and drops rd_valid the next cycle.
- DONE: done=1 and busy=0. Held until rst or an accepted start; any in_valid is ignored.
- Samples arriving in IDLE, READOUT or DONE are dropped silently.
- Arithmetic: counters are unsigned. wr_ptr never exceeds len-1, so there is no wrap; the effective length is clamped to DEPTH.

Decomposition:
- Shared package fir_capture_pkg:
  - state enum (IDLE, SKIP, CAPTURE, READOUT, DONE)
  - DATA_W/ADDR_W defaults
  - localparam DEPTH_DEFAULT = 1000
- One sub-module: capture_sample_ram.
  - Simple dual-port, 1 write port and 1 synchronous read port, DEPTH x DATA_W, 1-cycle read latency, no reset on the array.
- FSM, counters and read skid stay in fir_capture_buffer.

Test Plan:
1. Reset: assert rst 2 cycles with random inputs → busy=0, done=0, rd_valid=0, rd_data=0x0000, rd_index=0.
2. Basic: skip_count=3, capture_len=5, start, then in_data=0x0001..0x000A with in_valid=1 every cycle, rd_ready=1 → beats 0x0004,0x0005,0x0006,0x0007,0x0008, rd_index 0..4, rd_last on 0x0008 only, beats on consecutive cycles, then done=1.
3. Gapped input: skip_count=0, capture_len=4, in_valid toggling 1,0,1,0… with data 0x0010,xx,0x0011,xx,0x0012,xx,0x0013 → readout 0x0010..0x0013 exactly, no duplicates.
4. Backpressure: capture 8 samples 0xA000..0xA007, rd_ready random 50% → all 8 received in order; outputs stable whenever rd_valid && !rd_ready.
5. Full depth: capture_len=0, sine samples from sine200_input_data.txt → 1000 beats, rd_last at rd_index=999, data matches the driven stream.
6. Abort/ignore:
   - start pulsed again during CAPTURE → ignored, original length honored.
   - rst mid-CAPTURE after 3 writes → IDLE next cycle, no rd_valid.
   - New start with capture_len=2 → exactly 2 fresh samples read back.
